dmem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single data-memory port. It shares that port between the MEM pipeline stage and an auxiliary requester (loader/debug DMA). Each access is held stable for a fixed, parameterised memory latency. While a MEM-stage access is outstanding, the block stalls the pipeline. It sits between the MEM stage's `*_2DM` / `fDM` signals and the data memory.

---
 rtl/dmem_port_arbiter_if.sv | 42 ++++
 rtl/dmem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
//
// Signal bundle for the single data-memory port.
//
//   data_address_2DM     32  byte address presented to memory
//   data_write_2DM       32  store data
//   data_write_size_2DM   2  write size code (0 word, 1 byte, 2 half, 3 three bytes)
//   MemRead_2DM           1  read strobe
//   MemWrite_2DM          1  write strobe
//   data_read_fDM        32  read data returned by memory
//
// Modports:
//   master - the arbiter: drives address/data/size/strobes, receives read data
//   slave  - the memory:  receives address/data/size/strobes, drives read data
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if;
   logic [31:0] data_address_2DM;
   logic [31:0] data_write_2DM;
   logic [1:0]  data_write_size_2DM;
   logic        MemRead_2DM;
   logic        MemWrite_2DM;
   logic [31:0] data_read_fDM;

   modport master (
      output data_address_2DM,
      output data_write_2DM,
      output data_write_size_2DM,
      output MemRead_2DM,
      output MemWrite_2DM,
      input  data_read_fDM
   );

   modport slave (
      input  data_address_2DM,
      input  data_write_2DM,
      input  data_write_size_2DM,
      input  MemRead_2DM,
      input  MemWrite_2DM,
      output data_read_fDM
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port between the MEM pipeline stage and an
// auxiliary requester (loader / debug DMA). Each granted access holds its
// strobe for MEM_LATENCY cycles; read data is captured at the end of the last
// strobe cycle and a one-cycle done pulse follows. The pipeline is stalled
// while a MEM-stage request is pending or in flight.
//
// Handshake: a requester raises *_req_IN with stable we/addr/wdata/size and
// keeps it up until it sees its *_done_OUT pulse. Request fields are sampled
// only on the grant edge; later changes are ignored until the access ends.
// In the done cycle the just-served requester is not eligible for a grant,
// which gives the other requester a window after every access.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   mem_req_IN ..       MEM-stage request: req, we, addr[32], wdata[32], size[2]
//   mem_rdata_OUT       last completed MEM-stage load data
//   mem_done_OUT        one-cycle pulse when a MEM access completes
//   Stall_OUT           hold the pipeline (mem_req_IN & ~mem_done_OUT)
//   aux_req_IN ..       auxiliary request: req, we, addr[32], wdata[32], size[2]
//   aux_rdata_OUT       last completed aux load data
//   aux_done_OUT        one-cycle pulse when an aux access completes
//   dm                  data-memory port (master side)
//   dbg_state           current FSM state (0 IDLE, 1 BUSY_MEM, 2 BUSY_AUX)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int MEM_LATENCY = 2
) (
   input  logic        CLK,
   input  logic        RESET,

   input  logic        mem_req_IN,
   input  logic        mem_we_IN,
   input  logic [31:0] mem_addr_IN,
   input  logic [31:0] mem_wdata_IN,
   input  logic [1:0]  mem_size_IN,
   output logic [31:0] mem_rdata_OUT,
   output logic        mem_done_OUT,
   output logic        Stall_OUT,

   input  logic        aux_req_IN,
   input  logic        aux_we_IN,
   input  logic [31:0] aux_addr_IN,
   input  logic [31:0] aux_wdata_IN,
   input  logic [1:0]  aux_size_IN,
   output logic [31:0] aux_rdata_OUT,
   output logic        aux_done_OUT,

   dmem_port_arbiter_if.master dm,

   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_MEM = 2'd1,
      BUSY_AUX = 2'd2
   } state_t;

   // The counter holds the remaining strobe cycles minus one, so a value of
   // zero marks the final strobe cycle of the access.
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        grant_mem;
   logic        grant_aux;
   logic        last_cycle;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic [31:0] mem_rdata_q;
   logic [31:0] aux_rdata_q;
   logic        mem_done_q;
   logic        aux_done_q;

   assign last_cycle = (state != IDLE) && (cnt == 4'd0);

   // Next-state and grant decision. A requester whose done pulse is high has
   // just been served and is skipped this cycle.
   always_comb begin
      state_nxt = state;
      grant_mem = 1'b0;
      grant_aux = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req_IN && !mem_done_q) begin
               grant_mem = 1'b1;
               state_nxt = BUSY_MEM;
            end else if (aux_req_IN && !aux_done_q) begin
               grant_aux = 1'b1;
               state_nxt = BUSY_AUX;
            end
         end
         BUSY_MEM, BUSY_AUX: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         size_q      <= 2'd0;
         mem_rdata_q <= 32'd0;
         aux_rdata_q <= 32'd0;
         mem_done_q  <= 1'b0;
         aux_done_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         mem_done_q <= 1'b0;
         aux_done_q <= 1'b0;
         if (grant_mem) begin
            we_q    <= mem_we_IN;
            addr_q  <= mem_addr_IN;
            wdata_q <= mem_wdata_IN;
            size_q  <= mem_size_IN;
            cnt     <= CNT_LOAD;
         end else if (grant_aux) begin
            we_q    <= aux_we_IN;
            addr_q  <= aux_addr_IN;
            wdata_q <= aux_wdata_IN;
            size_q  <= aux_size_IN;
            cnt     <= CNT_LOAD;
         end else if (last_cycle) begin
            // Read data is valid during the final strobe cycle.
            if (state == BUSY_MEM) begin
               mem_done_q <= 1'b1;
               if (!we_q) begin
                  mem_rdata_q <= dm.data_read_fDM;
               end
            end else begin
               aux_done_q <= 1'b1;
               if (!we_q) begin
                  aux_rdata_q <= dm.data_read_fDM;
               end
            end
         end else if (state != IDLE) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Strobes derive from the state register so an asynchronous reset drops
   // them at once; address/data/size simply hold their last latched values.
   assign dm.MemRead_2DM         = (state != IDLE) && !we_q;
   assign dm.MemWrite_2DM        = (state != IDLE) &&  we_q;
   assign dm.data_address_2DM    = addr_q;
   assign dm.data_write_2DM      = wdata_q;
   assign dm.data_write_size_2DM = size_q;

   assign mem_rdata_OUT = mem_rdata_q;
   assign aux_rdata_OUT = aux_rdata_q;
   assign mem_done_OUT  = mem_done_q;
   assign aux_done_OUT  = aux_done_q;

   // Covers both waiting for the port and the access itself.
   assign Stall_OUT = mem_req_IN & ~mem_done_q;

   assign dbg_state = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Two instances share one stimulus stream: dut0 with MEM_LATENCY=2 and dut1
// with MEM_LATENCY=1. A reference model reasons in terms of grant times:
// an access granted in cycle g strobes in g+1..g+L, completes in g+L+1 and
// the port can be re-arbitrated from cycle g+L+1 with the served requester
// skipped in that cycle.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- stimulus ----------------
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [1:0]  mem_size = '0;
   logic        aux_req = 1'b0;
   logic        aux_we = 1'b0;
   logic [31:0] aux_addr = '0;
   logic [31:0] aux_wdata = '0;
   logic [1:0]  aux_size = '0;
   logic [31:0] fdm = '0;

   // ---------------- DUT outputs ----------------
   logic [31:0] mem_rdata0, mem_rdata1, aux_rdata0, aux_rdata1;
   logic        mem_done0, mem_done1, aux_done0, aux_done1;
   logic        stall0, stall1;
   logic [1:0]  dbg0, dbg1;

   dmem_port_arbiter_if bus0 ();
   dmem_port_arbiter_if bus1 ();
   assign bus0.data_read_fDM = fdm;
   assign bus1.data_read_fDM = fdm;

   dmem_port_arbiter #(.MEM_LATENCY(LAT0)) dut0 (
      .CLK(CLK), .RESET(RESET),
      .mem_req_IN(mem_req), .mem_we_IN(mem_we), .mem_addr_IN(mem_addr),
      .mem_wdata_IN(mem_wdata), .mem_size_IN(mem_size),
      .mem_rdata_OUT(mem_rdata0), .mem_done_OUT(mem_done0), .Stall_OUT(stall0),
      .aux_req_IN(aux_req), .aux_we_IN(aux_we), .aux_addr_IN(aux_addr),
      .aux_wdata_IN(aux_wdata), .aux_size_IN(aux_size),
      .aux_rdata_OUT(aux_rdata0), .aux_done_OUT(aux_done0),
      .dm(bus0.master), .dbg_state(dbg0)
   );

   dmem_port_arbiter #(.MEM_LATENCY(LAT1)) dut1 (
      .CLK(CLK), .RESET(RESET),
      .mem_req_IN(mem_req), .mem_we_IN(mem_we), .mem_addr_IN(mem_addr),
      .mem_wdata_IN(mem_wdata), .mem_size_IN(mem_size),
      .mem_rdata_OUT(mem_rdata1), .mem_done_OUT(mem_done1), .Stall_OUT(stall1),
      .aux_req_IN(aux_req), .aux_we_IN(aux_we), .aux_addr_IN(aux_addr),
      .aux_wdata_IN(aux_wdata), .aux_size_IN(aux_size),
      .aux_rdata_OUT(aux_rdata1), .aux_done_OUT(aux_done1),
      .dm(bus1.master), .dbg_state(dbg1)
   );

   // ---------------- bookkeeping ----------------
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [31:0] prev_fdm = '0;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_val = '0;

   // ---------------- reference model ----------------
   typedef struct {
      bit          valid;
      int          g;
      bit          mem;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
   } grant_t;

   grant_t      lg [2];
   logic [31:0] m_rd [2];
   logic [31:0] a_rd [2];

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         lg[d].valid = 1'b0;
         lg[d].g     = 0;
         lg[d].mem   = 1'b0;
         lg[d].we    = 1'b0;
         lg[d].addr  = '0;
         lg[d].wdata = '0;
         lg[d].size  = '0;
         m_rd[d]     = '0;
         a_rd[d]     = '0;
      end
   endfunction

   // Expected outputs for the current cycle, then the grant decision for it.
   // Packing: {mem_done, aux_done, stall, rd, wr, size, addr, wdata, mem_rdata, aux_rdata}
   function automatic logic [134:0] model_cycle(input int d);
      int          lat;
      bit          busy, dm, da, we, free;
      logic [31:0] addr, wd;
      logic [1:0]  sz;
      lat  = (d == 0) ? LAT0 : LAT1;
      busy = 1'b0; dm = 1'b0; da = 1'b0; we = 1'b0;
      addr = '0; wd = '0; sz = '0;
      if (lg[d].valid) begin
         busy = (cyc > lg[d].g) && (cyc <= lg[d].g + lat);
         dm   =  lg[d].mem && (cyc == lg[d].g + lat + 1);
         da   = !lg[d].mem && (cyc == lg[d].g + lat + 1);
         we   = lg[d].we;
         addr = lg[d].addr;
         wd   = lg[d].wdata;
         sz   = lg[d].size;
      end
      if (dm && !we) m_rd[d] = prev_fdm;
      if (da && !we) a_rd[d] = prev_fdm;
      model_cycle = {dm, da, mem_req & ~dm, busy & ~we, busy & we, sz, addr, wd, m_rd[d], a_rd[d]};
      free = !lg[d].valid || (cyc > lg[d].g + lat);
      if (free) begin
         if (mem_req && !dm) begin
            lg[d] = '{1'b1, cyc, 1'b1, mem_we, mem_addr, mem_wdata, mem_size};
         end else if (aux_req && !da) begin
            lg[d] = '{1'b1, cyc, 1'b0, aux_we, aux_addr, aux_wdata, aux_size};
         end
      end
   endfunction

   function automatic logic [134:0] obs(input int d);
      if (d == 0)
         return {mem_done0, aux_done0, stall0, bus0.MemRead_2DM, bus0.MemWrite_2DM,
                 bus0.data_write_size_2DM, bus0.data_address_2DM, bus0.data_write_2DM,
                 mem_rdata0, aux_rdata0};
      return {mem_done1, aux_done1, stall1, bus1.MemRead_2DM, bus1.MemWrite_2DM,
              bus1.data_write_size_2DM, bus1.data_address_2DM, bus1.data_write_2DM,
              mem_rdata1, aux_rdata1};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge CLK);
      #1;
      cyc++;
      prev_fdm = fdm;
      fdm = use_fixed ? fixed_val : $urandom;
   endtask

   task automatic set_mem(input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size);
      mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_size = size;
   endtask

   task automatic set_aux(input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size);
      aux_req = req; aux_we = we; aux_addr = addr; aux_wdata = wdata; aux_size = size;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [134:0] e;
      for (int t = 0; t < 4; t++) begin
         next_cycle();
         set_mem(1'b0, 1'b0, '0, '0, '0);
         set_aux(1'b0, 1'b0, '0, '0, '0);
         if (t == 2) RESET = 1'b1;
         @(negedge CLK);
         if (t < 2) begin
            vectors++;
            if (obs(0) !== '0 || dbg0 !== 2'd0) begin
               miscompares++;
               $display("FAIL reset d0 t%0d: got %h st %0d want 0", t, obs(0), dbg0);
            end
            vectors++;
            if (obs(1) !== '0 || dbg1 !== 2'd0) begin
               miscompares++;
               $display("FAIL reset d1 t%0d: got %h st %0d want 0", t, obs(1), dbg1);
            end
         end else begin
            for (int d = 0; d < 2; d++) begin
               e = model_cycle(d);
               vectors++;
               if (obs(d) !== e) begin
                  miscompares++;
                  $display("FAIL reset_idle d%0d t%0d: got %h want %h", d, t, obs(d), e);
               end
            end
         end
      end
   endtask

   task automatic test_mem_load();
      logic [134:0] e;
      use_fixed = 1'b1;
      fixed_val = 32'hDEADBEEF;
      for (int t = 0; t < 8; t++) begin
         next_cycle();
         set_mem(t <= 3, 1'b0, 32'h100, 32'h0, 2'd0);
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL mem_load d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
         if (t >= 1 && t <= 2) begin
            vectors++;
            if (bus0.MemRead_2DM !== 1'b1 || bus0.data_address_2DM !== 32'h100) begin
               miscompares++;
               $display("FAIL load_strobe t%0d: got rd %b addr %h want 1 100", t, bus0.MemRead_2DM, bus0.data_address_2DM);
            end
         end
         if (t == 3) begin
            vectors++;
            if (mem_done0 !== 1'b1 || mem_rdata0 !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL load_done t%0d: got done %b data %h want 1 deadbeef", t, mem_done0, mem_rdata0);
            end
         end
         if (t <= 3) begin
            vectors++;
            if (stall0 !== (t <= 2)) begin
               miscompares++;
               $display("FAIL load_stall t%0d: got %b want %b", t, stall0, t <= 2);
            end
         end
      end
      use_fixed = 1'b0;
   endtask

   task automatic test_mem_store();
      logic [134:0] e;
      for (int t = 0; t < 8; t++) begin
         next_cycle();
         set_mem(t <= 3, 1'b1, 32'h203, 32'h0000_00AB, 2'd1);
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL mem_store d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
         if (t >= 1 && t <= 2) begin
            vectors++;
            if (bus0.MemWrite_2DM !== 1'b1 || bus0.MemRead_2DM !== 1'b0 ||
                bus0.data_write_size_2DM !== 2'd1 || bus0.data_write_2DM !== 32'hAB) begin
               miscompares++;
               $display("FAIL store_strobe t%0d: got wr %b rd %b size %0d data %h want 1 0 1 ab",
                        t, bus0.MemWrite_2DM, bus0.MemRead_2DM, bus0.data_write_size_2DM, bus0.data_write_2DM);
            end
         end
         if (t == 3) begin
            vectors++;
            if (mem_done0 !== 1'b1 || mem_rdata0 !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL store_done t%0d: got done %b rdata %h want 1 deadbeef", t, mem_done0, mem_rdata0);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [134:0] e;
      logic [31:0]  wd;
      wd = $urandom;
      for (int t = 0; t < 14; t++) begin
         next_cycle();
         if (t < 4) set_mem(1'b1, 1'b0, 32'h110, 32'h0, 2'd0);
         else       set_mem(t <= 9, 1'b1, 32'h300, wd, 2'd0);
         set_aux(t <= 6, 1'b0, 32'h400, 32'h0, 2'd0);
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL simultaneous d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
         if (t >= 4 && t <= 5) begin
            vectors++;
            if (bus0.MemRead_2DM !== 1'b1 || bus0.data_address_2DM !== 32'h400) begin
               miscompares++;
               $display("FAIL sim_aux_strobe t%0d: got rd %b addr %h want 1 400", t, bus0.MemRead_2DM, bus0.data_address_2DM);
            end
         end
         if (t == 3 || t == 6) begin
            vectors++;
            if ({mem_done0, aux_done0} !== ((t == 3) ? 2'b10 : 2'b01)) begin
               miscompares++;
               $display("FAIL sim_done t%0d: got %b%b want %b", t, mem_done0, aux_done0, (t == 3) ? 2'b10 : 2'b01);
            end
         end
      end
   endtask

   task automatic test_aux_then_mem();
      logic [134:0] e;
      for (int t = 0; t < 10; t++) begin
         next_cycle();
         set_aux(t <= 3, 1'b0, 32'h500, 32'h0, 2'd0);
         set_mem(t >= 1 && t <= 6, 1'b0, 32'h600, 32'h0, 2'd0);
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL aux_then_mem d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
         if (t <= 6) begin
            vectors++;
            if (stall0 !== (t >= 1 && t <= 5) || mem_done0 !== (t == 6)) begin
               miscompares++;
               $display("FAIL aux_mem_stall t%0d: got stall %b done %b want %b %b",
                        t, stall0, mem_done0, t >= 1 && t <= 5, t == 6);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [134:0] e;
      logic [134:0] z;
      for (int t = 0; t < 9; t++) begin
         next_cycle();
         set_mem(t <= 6, 1'b0, 32'h700, 32'h0, 2'd0);
         if (t == 2) RESET = 1'b1;
         if (t == 1) begin
            #1 RESET = 1'b0;
            #1;
            z = '0;
            z[132] = 1'b1;
            for (int d = 0; d < 2; d++) begin
               vectors++;
               if (obs(d) !== z) begin
                  miscompares++;
                  $display("FAIL reset_mid d%0d: got %h want %h", d, obs(d), z);
               end
            end
            model_reset();
         end else begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
               e = model_cycle(d);
               vectors++;
               if (obs(d) !== e) begin
                  miscompares++;
                  $display("FAIL reset_regrant d%0d t%0d: got %h want %h", d, t, obs(d), e);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back_lat1();
      logic [134:0] e;
      for (int t = 0; t < 10; t++) begin
         next_cycle();
         set_mem(t <= 5, 1'b0, 32'h800, 32'h0, 2'd0);
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL back_to_back d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
         if (t <= 6) begin
            vectors++;
            if (bus1.MemRead_2DM !== (t == 1 || t == 4) || mem_done1 !== (t == 2 || t == 5)) begin
               miscompares++;
               $display("FAIL lat1_b2b t%0d: got rd %b done %b want %b %b",
                        t, bus1.MemRead_2DM, mem_done1, t == 1 || t == 4, t == 2 || t == 5);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [134:0] e;
      for (int t = 0; t < 400; t++) begin
         next_cycle();
         if (t < 394) begin
            set_mem($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
            set_aux($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
         end else begin
            set_mem(1'b0, 1'b0, '0, '0, '0);
            set_aux(1'b0, 1'b0, '0, '0, '0);
         end
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            e = model_cycle(d);
            vectors++;
            if (obs(d) !== e) begin
               miscompares++;
               $display("FAIL random d%0d t%0d: got %h want %h", d, t, obs(d), e);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      model_reset();
      test_reset();
      test_mem_load();
      test_mem_store();
      test_simultaneous();
      test_aux_then_mem();
      test_reset_mid();
      test_back_to_back_lat1();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
